// File: rtl/ahb_apb_pkg.sv
// Shared types and AHB encodings for the AHB-lite to APB bridge.
package ahb_apb_pkg;

   // Bridge FSM states
   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StAccess,
      StErr1,
      StErr2
   } state_e;

   // HTRANS encodings
   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransBusy   = 2'b01;
   localparam logic [1:0] HtransNonseq = 2'b10;
   localparam logic [1:0] HtransSeq    = 2'b11;

   // HRESP encodings
   localparam logic RespOkay  = 1'b0;
   localparam logic RespError = 1'b1;

endpackage

// File: rtl/ahb_apb_bridge.sv
// AHB-lite slave to APB master bridge: one APB SETUP/ACCESS per AHB single transfer,
// AHB data phase stalled while APB is busy, PSLVERR/timeout mapped to a 2-cycle ERROR.
module ahb_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned PADDR_W = 16,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               HSEL,
   input  logic [ADDR_W-1:0]  HADDR,
   input  logic [1:0]         HTRANS,
   input  logic               HWRITE,
   input  logic [DATA_W-1:0]  HWDATA,
   input  logic               HREADY,
   output logic               HREADYOUT,
   output logic               HRESP,
   output logic [DATA_W-1:0]  HRDATA,
   output logic               PSEL,
   output logic               PENABLE,
   output logic [PADDR_W-1:0] PADDR,
   output logic               PWRITE,
   output logic [DATA_W-1:0]  PWDATA,
   input  logic [DATA_W-1:0]  PRDATA,
   input  logic               PREADY,
   input  logic               PSLVERR
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                hreadyout_q;
   logic                hresp_q;
   logic [DATA_W-1:0]   hrdata_q;
   logic                psel_q;
   logic                penable_q;
   logic [PADDR_W-1:0]  addr_q;
   logic                write_q;

   logic valid;
   logic timeout_hit;
   logic unused_in;

   assign valid       = HSEL & HREADY & HTRANS[1];
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // Upper address bits and HTRANS[0] do not affect the APB side
   assign unused_in = ^{HADDR[ADDR_W-1:PADDR_W], HTRANS[0]};

   // Write data is safe to pass through: the master holds HWDATA while we stall
   assign PWDATA    = HWDATA;
   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = hrdata_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PADDR     = addr_q;
   assign PWRITE    = write_q;

   // Bridge FSM with registered AHB/APB outputs and ACCESS timeout counter
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= RespOkay;
         hrdata_q    <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         addr_q      <= '0;
         write_q     <= 1'b0;
      end else begin
         unique case (state_q)
            // ERR2 is the second error cycle but accepts a new address phase like IDLE
            StIdle, StErr2: begin
               if (valid) begin
                  state_q     <= StSetup;
                  cnt_q       <= '0;
                  hreadyout_q <= 1'b0;
                  hresp_q     <= RespOkay;
                  psel_q      <= 1'b1;
                  penable_q   <= 1'b0;
                  addr_q      <= HADDR[PADDR_W-1:0];
                  write_q     <= HWRITE;
               end else begin
                  state_q     <= StIdle;
                  hreadyout_q <= 1'b1;
                  hresp_q     <= RespOkay;
               end
            end
            StSetup: begin
               state_q   <= StAccess;
               penable_q <= 1'b1;
            end
            StAccess: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (PREADY) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  if (PSLVERR) begin
                     state_q <= StErr1;
                     hresp_q <= RespError;
                  end else begin
                     state_q     <= StIdle;
                     hreadyout_q <= 1'b1;
                     if (!write_q) begin
                        hrdata_q <= PRDATA;
                     end
                  end
               end else if (timeout_hit) begin
                  // Abandon the APB access; a late PREADY lands in ERR1 and is ignored
                  state_q   <= StErr1;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  hresp_q   <= RespError;
               end
            end
            StErr1: begin
               state_q     <= StErr2;
               hreadyout_q <= 1'b1;
               hresp_q     <= RespError;
            end
            default: begin
               state_q     <= StIdle;
               hreadyout_q <= 1'b1;
               hresp_q     <= RespOkay;
               psel_q      <= 1'b0;
               penable_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge. Inputs change and outputs are
// sampled on the falling edge; the bridge is the only slave so HREADY = HREADYOUT.
module tb_ahb_apb_bridge;
   import ahb_apb_pkg::*;

   logic        hclk;
   logic        hresetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic        psel;
   logic        penable;
   logic [15:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_checks = 0;
   int n_pass   = 0;

   assign hready = hreadyout;

   ahb_apb_bridge #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .PADDR_W (16),
      .TIMEOUT (16)
   ) dut (
      .HCLK      (hclk),
      .HRESETn   (hresetn),
      .HSEL      (hsel),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HWDATA    (hwdata),
      .HREADY    (hready),
      .HREADYOUT (hreadyout),
      .HRESP     (hresp),
      .HRDATA    (hrdata),
      .PSEL      (psel),
      .PENABLE   (penable),
      .PADDR     (paddr),
      .PWRITE    (pwrite),
      .PWDATA    (pwdata),
      .PRDATA    (prdata),
      .PREADY    (pready),
      .PSLVERR   (pslverr)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge hclk);
   endtask

   // Present an address phase; it is sampled on the next rising edge
   task automatic addr_phase(input logic [31:0] a, input logic w);
      hsel   = 1'b1;
      htrans = HtransNonseq;
      haddr  = a;
      hwrite = w;
   endtask

   task automatic bus_idle();
      hsel   = 1'b0;
      htrans = HtransIdle;
   endtask

   initial begin
      hresetn = 1'b0;
      hsel    = 1'b0;
      haddr   = '0;
      htrans  = HtransIdle;
      hwrite  = 1'b0;
      hwdata  = '0;
      prdata  = '0;
      pready  = 1'b0;
      pslverr = 1'b0;

      // Reset state
      tick();
      check_eq("rst_hreadyout", hreadyout, 1);
      check_eq("rst_hresp", hresp, 0);
      check_eq("rst_hrdata", hrdata, 0);
      check_eq("rst_psel", psel, 0);
      check_eq("rst_penable", penable, 0);
      check_eq("rst_paddr", paddr, 0);
      check_eq("rst_pwrite", pwrite, 0);
      hresetn = 1'b1;
      tick();

      // Single write, zero wait states
      addr_phase(32'h0000_1234, 1'b1);
      pready = 1'b1;
      tick();
      check_eq("wr_setup_psel", psel, 1);
      check_eq("wr_setup_penable", penable, 0);
      check_eq("wr_setup_hreadyout", hreadyout, 0);
      check_eq("wr_setup_paddr", paddr, 32'h1234);
      check_eq("wr_setup_pwrite", pwrite, 1);
      bus_idle();
      hwdata = 32'hDEAD_BEEF;
      tick();
      check_eq("wr_access_psel", psel, 1);
      check_eq("wr_access_penable", penable, 1);
      check_eq("wr_access_hreadyout", hreadyout, 0);
      check_eq("wr_access_pwdata", pwdata, 32'hDEAD_BEEF);
      check_eq("wr_access_paddr", paddr, 32'h1234);
      tick();
      check_eq("wr_done_hreadyout", hreadyout, 1);
      check_eq("wr_done_hresp", hresp, 0);
      check_eq("wr_done_psel", psel, 0);
      check_eq("wr_done_penable", penable, 0);
      check_eq("wr_done_paddr_hold", paddr, 32'h1234);
      check_eq("wr_hrdata_unchanged", hrdata, 0);

      // Read with three wait states: SETUP + 4 ACCESS = 5 stalled cycles
      addr_phase(32'h0000_0040, 1'b0);
      pready = 1'b0;
      prdata = 32'hA5A5_0001;
      tick();
      bus_idle();
      for (int i = 1; i <= 5; i++) begin
         check_eq($sformatf("rd_stall%0d", i), hreadyout, 0);
         check_eq($sformatf("rd_penable%0d", i), penable, (i == 1) ? 0 : 1);
         if (i == 5) pready = 1'b1;
         tick();
      end
      check_eq("rd_done_hreadyout", hreadyout, 1);
      check_eq("rd_done_hrdata", hrdata, 32'hA5A5_0001);
      check_eq("rd_done_hresp", hresp, 0);
      check_eq("rd_paddr", paddr, 32'h0040);
      check_eq("rd_pwrite", pwrite, 0);

      // PSLVERR mapped to two-cycle ERROR
      addr_phase(32'h0000_0020, 1'b1);
      pready  = 1'b1;
      pslverr = 1'b1;
      tick();
      bus_idle();
      tick();
      check_eq("slverr_access_penable", penable, 1);
      tick();
      pslverr = 1'b0;
      check_eq("slverr_err1_hreadyout", hreadyout, 0);
      check_eq("slverr_err1_hresp", hresp, 1);
      check_eq("slverr_err1_psel", psel, 0);
      tick();
      check_eq("slverr_err2_hreadyout", hreadyout, 1);
      check_eq("slverr_err2_hresp", hresp, 1);
      tick();
      check_eq("slverr_idle_hresp", hresp, 0);
      check_eq("slverr_idle_hreadyout", hreadyout, 1);
      check_eq("slverr_hrdata_kept", hrdata, 32'hA5A5_0001);

      // Timeout after 16 ACCESS cycles with PREADY low
      addr_phase(32'h0000_0030, 1'b0);
      pready = 1'b0;
      prdata = 32'h0BAD_0BAD;
      tick();
      bus_idle();
      check_eq("to_setup_psel", psel, 1);
      for (int i = 1; i <= 16; i++) begin
         tick();
         check_eq($sformatf("to_access%0d_penable", i), penable, 1);
      end
      tick();
      check_eq("to_err1_psel", psel, 0);
      check_eq("to_err1_penable", penable, 0);
      check_eq("to_err1_hresp", hresp, 1);
      check_eq("to_err1_hreadyout", hreadyout, 0);
      pready = 1'b1;
      tick();
      pready = 1'b0;
      check_eq("to_err2_hresp", hresp, 1);
      check_eq("to_err2_hreadyout", hreadyout, 1);
      check_eq("to_err2_psel", psel, 0);
      tick();
      check_eq("to_idle_hresp", hresp, 0);
      check_eq("to_idle_psel", psel, 0);
      check_eq("to_hrdata_kept", hrdata, 32'hA5A5_0001);

      // Back-to-back: write 0x10, read 0x14 issued on the completion cycle
      addr_phase(32'h0000_0010, 1'b1);
      pready = 1'b1;
      tick();
      bus_idle();
      hwdata = 32'h1111_1111;
      check_eq("b2b_wr_paddr", paddr, 32'h0010);
      tick();
      tick();
      check_eq("b2b_complete_hreadyout", hreadyout, 1);
      addr_phase(32'h0000_0014, 1'b0);
      prdata = 32'hCAFE_F00D;
      tick();
      bus_idle();
      check_eq("b2b_rd_setup_psel", psel, 1);
      check_eq("b2b_rd_setup_penable", penable, 0);
      check_eq("b2b_rd_paddr", paddr, 32'h0014);
      check_eq("b2b_rd_pwrite", pwrite, 0);
      tick();
      tick();
      check_eq("b2b_rd_hrdata", hrdata, 32'hCAFE_F00D);
      check_eq("b2b_rd_hreadyout", hreadyout, 1);

      // Asynchronous reset in the middle of ACCESS
      addr_phase(32'h0000_0050, 1'b1);
      pready = 1'b0;
      tick();
      bus_idle();
      tick();
      check_eq("rstmid_access_penable", penable, 1);
      #2 hresetn = 1'b0;
      #1;
      check_eq("rstmid_psel", psel, 0);
      check_eq("rstmid_penable", penable, 0);
      check_eq("rstmid_hreadyout", hreadyout, 1);
      check_eq("rstmid_hrdata", hrdata, 0);
      tick();
      hresetn = 1'b1;
      tick();
      addr_phase(32'h0000_0060, 1'b1);
      pready = 1'b1;
      tick();
      bus_idle();
      hwdata = 32'h6060_6060;
      check_eq("post_rst_paddr", paddr, 32'h0060);
      check_eq("post_rst_psel", psel, 1);
      tick();
      check_eq("post_rst_pwdata", pwdata, 32'h6060_6060);
      tick();
      check_eq("post_rst_hreadyout", hreadyout, 1);
      check_eq("post_rst_hresp", hresp, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
